// File: rtl/inst_fetch_queue.sv
// Dual-lane circular instruction queue between fetch and IF/ID.
// Accepts up to two pushes and two pops per cycle; flush empties the queue in one cycle.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Flush,
    input  logic                     Stall,
    input  logic [1:0]               InValid,
    input  logic [WIDTH-1:0]         InInstr0,
    input  logic [WIDTH-1:0]         InInstr1,
    input  logic [WIDTH-1:0]         InPC0,
    input  logic [WIDTH-1:0]         InPC1,
    output logic                     Full,
    input  logic [1:0]               DeqNum,
    output logic [1:0]               OutValid,
    output logic [WIDTH-1:0]         OutInstr0,
    output logic [WIDTH-1:0]         OutInstr1,
    output logic [WIDTH-1:0]         OutPC0,
    output logic [WIDTH-1:0]         OutPC1,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] head1, tail1;
    logic [1:0]    push_n, pop_n, avail;
    logic          wr0_en, wr1_en;

    always_comb begin
        head1  = head_q + AW'(1);
        tail1  = tail_q + AW'(1);

        // Lane 1 push is only meaningful behind a valid lane 0.
        push_n = 2'd0;
        if (!Full && !Flush) begin
            case (InValid)
                2'b11:   push_n = 2'd2;
                2'b01:   push_n = 2'd1;
                default: push_n = 2'd0;
            endcase
        end

        avail = OutValid[1] ? 2'd2 : (OutValid[0] ? 2'd1 : 2'd0);
        pop_n = 2'd0;
        if (!Stall && !Flush) begin
            pop_n = (DeqNum > avail) ? avail : DeqNum;
        end

        wr0_en = (push_n != 2'd0);
        wr1_en = (push_n == 2'd2);

        if (Flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop_n);
            tail_d  = tail_q + AW'(push_n);
            count_d = count_q + CW'(push_n) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; outputs are masked by OutValid instead.
    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[tail_q] <= '{instr: InInstr0, pc: InPC0};
        if (wr1_en) mem_q[tail1]  <= '{instr: InInstr1, pc: InPC1};
    end

    always_comb begin
        OutValid  = {count_q >= CW'(2), count_q != '0};
        Full      = count_q > CW'(DEPTH - 2);
        Count     = count_q;
        OutInstr0 = OutValid[0] ? mem_q[head_q].instr : '0;
        OutPC0    = OutValid[0] ? mem_q[head_q].pc    : '0;
        OutInstr1 = OutValid[1] ? mem_q[head1].instr  : '0;
        OutPC1    = OutValid[1] ? mem_q[head1].pc     : '0;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = 3 + CW + 4 * WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             Flush = 1'b0;
    logic             Stall = 1'b0;
    logic [1:0]       InValid = 2'b00;
    logic [WIDTH-1:0] InInstr0 = '0, InInstr1 = '0, InPC0 = '0, InPC1 = '0;
    logic             Full;
    logic [1:0]       DeqNum = 2'd0;
    logic [1:0]       OutValid;
    logic [WIDTH-1:0] OutInstr0, OutInstr1, OutPC0, OutPC1;
    logic [CW-1:0]    Count;

    inst_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .Flush(Flush), .Stall(Stall),
        .InValid(InValid), .InInstr0(InInstr0), .InInstr1(InInstr1),
        .InPC0(InPC0), .InPC1(InPC1), .Full(Full), .DeqNum(DeqNum),
        .OutValid(OutValid), .OutInstr0(OutInstr0), .OutInstr1(OutInstr1),
        .OutPC0(OutPC0), .OutPC1(OutPC1), .Count(Count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;

    logic [VW-1:0] obs_vec;
    assign obs_vec = {OutValid, Full, Count, OutInstr0, OutPC0, OutInstr1, OutPC1};

    function automatic logic [VW-1:0] exp_vec();
        int n;
        logic [1:0] v;
        ent_t e0, e1;
        n  = q.size();
        v  = {n >= 2, n >= 1};
        e0 = '0;
        e1 = '0;
        if (n >= 1) e0 = q[0];
        if (n >= 2) e1 = q[1];
        return {v, 1'(n > DEPTH - 2), CW'(n), e0.instr, e0.pc, e1.instr, e1.pc};
    endfunction

    // Drive one cycle of stimulus, advance the model, then sit 1ns past the edge.
    task automatic cycle(input logic [1:0] inval, input logic [1:0] deq,
                         input logic stall, input logic flush,
                         input logic [WIDTH-1:0] pc0, input logic [WIDTH-1:0] pc1);
        int d;
        bit full_now;
        InValid  = inval;
        DeqNum   = deq;
        Stall    = stall;
        Flush    = flush;
        InPC0    = pc0;
        InPC1    = pc1;
        InInstr0 = $urandom;
        InInstr1 = $urandom;
        full_now = q.size() > DEPTH - 2;
        if (flush) begin
            q.delete();
        end else begin
            d = stall ? 0 : int'(deq);
            if (d > q.size()) d = q.size();
            if (d > 2) d = 2;
            repeat (d) void'(q.pop_front());
            if (!full_now && inval[0]) begin
                q.push_back('{instr: InInstr0, pc: pc0});
                if (inval[1]) q.push_back('{instr: InInstr1, pc: pc1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_vec !== exp_vec() || obs_vec !== '0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", obs_vec);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) cycle(2'b11, 2'd0, 1'b0, 1'b0, WIDTH'(8 * k), WIDTH'(8 * k + 4));
        total++;
        if (Count !== CW'(8) || Full !== 1'b1) begin
            bad++;
            $display("FAIL fill_full: got count=%0d full=%b want count=8 full=1", Count, Full);
        end
        cycle(2'b11, 2'd0, 1'b0, 1'b0, 32'h20, 32'h24);
        total++;
        if (Count !== CW'(8) || obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL fill_overflow: got count=%0d vec=%h want count=8 vec=%h", Count, obs_vec, exp_vec());
        end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (OutValid !== 2'b11 || OutPC0 !== WIDTH'(8 * k) || OutPC1 !== WIDTH'(8 * k + 4)) begin
                bad++;
                $display("FAIL drain_pair%0d: got v=%b pc0=%h pc1=%h want v=11 pc0=%h pc1=%h",
                         k, OutValid, OutPC0, OutPC1, 8 * k, 8 * k + 4);
            end
            cycle(2'b00, 2'd2, 1'b0, 1'b0, '0, '0);
        end
        total++;
        if (obs_vec !== '0) begin
            bad++;
            $display("FAIL drain_empty: got %h want 0", obs_vec);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] next_pc, pop_pc;
        logic [1:0] iv;
        next_pc = 32'h1000;
        pop_pc  = 32'h1000;
        for (int k = 0; k < 20; k++) begin
            iv = (k % 2 == 0) ? 2'b01 : 2'b11;
            if (OutValid[0]) begin
                total++;
                if (OutPC0 !== pop_pc) begin
                    bad++;
                    $display("FAIL wrap_order%0d: got pc=%h want pc=%h", k, OutPC0, pop_pc);
                end
                pop_pc = pop_pc + 4;
            end
            if (q.size() <= DEPTH - 2) begin
                cycle(iv, 2'd1, 1'b0, 1'b0, next_pc, next_pc + 4);
                next_pc = next_pc + (iv == 2'b11 ? 8 : 4);
            end else begin
                cycle(iv, 2'd1, 1'b0, 1'b0, next_pc, next_pc + 4);
            end
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_state%0d: got %h want %h", k, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_stall_overpop();
        logic [VW-1:0] snap;
        cycle(2'b00, 2'd0, 1'b0, 1'b1, '0, '0);
        cycle(2'b01, 2'd0, 1'b0, 1'b0, 32'h200, '0);
        total++;
        if (Count !== CW'(1)) begin
            bad++;
            $display("FAIL overpop_setup: got count=%0d want 1", Count);
        end
        cycle(2'b00, 2'd2, 1'b0, 1'b0, '0, '0);
        total++;
        if (Count !== CW'(0) || obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL overpop_clip: got count=%0d vec=%h want count=0", Count, obs_vec);
        end
        cycle(2'b11, 2'd0, 1'b0, 1'b0, 32'h210, 32'h214);
        cycle(2'b01, 2'd0, 1'b0, 1'b0, 32'h218, '0);
        snap = obs_vec;
        cycle(2'b00, 2'd2, 1'b1, 1'b0, '0, '0);
        total++;
        if (Count !== CW'(3) || obs_vec !== snap || obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL stall_hold: got count=%0d vec=%h want count=3 vec=%h", Count, obs_vec, snap);
        end
    endtask

    task automatic test_flush();
        cycle(2'b00, 2'd0, 1'b0, 1'b1, '0, '0);
        cycle(2'b11, 2'd0, 1'b0, 1'b0, 32'h40, 32'h44);
        cycle(2'b11, 2'd0, 1'b0, 1'b0, 32'h48, 32'h4c);
        cycle(2'b01, 2'd0, 1'b0, 1'b0, 32'h50, '0);
        total++;
        if (Count !== CW'(5)) begin
            bad++;
            $display("FAIL flush_setup: got count=%0d want 5", Count);
        end
        cycle(2'b11, 2'd2, 1'b0, 1'b1, 32'h60, 32'h64);
        total++;
        if (Count !== CW'(0) || OutValid !== 2'b00 || Full !== 1'b0 || obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL flush_priority: got count=%0d v=%b full=%b want 0 00 0", Count, OutValid, Full);
        end
        cycle(2'b01, 2'd0, 1'b0, 1'b0, 32'h100, '0);
        total++;
        if (OutPC0 !== 32'h100 || OutValid !== 2'b01) begin
            bad++;
            $display("FAIL flush_then_push: got pc0=%h v=%b want pc0=100 v=01", OutPC0, OutValid);
        end
    endtask

    task automatic test_async_reset();
        cycle(2'b00, 2'd0, 1'b0, 1'b1, '0, '0);
        for (int k = 0; k < 3; k++) cycle(2'b11, 2'd0, 1'b0, 1'b0, WIDTH'(32'h80 + 8 * k), WIDTH'(32'h84 + 8 * k));
        total++;
        if (Count !== CW'(6)) begin
            bad++;
            $display("FAIL async_setup: got count=%0d want 6", Count);
        end
        InValid = 2'b00;
        #2 reset = 1'b1;
        #1;
        q.delete();
        total++;
        if (obs_vec !== '0) begin
            bad++;
            $display("FAIL async_reset_immediate: got %h want 0", obs_vec);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        InValid = 2'b01;
        InPC0   = 32'h300;
        #1;
        total++;
        if (OutValid !== 2'b00) begin
            bad++;
            $display("FAIL no_bypass: got v=%b want 00", OutValid);
        end
        cycle(2'b01, 2'd0, 1'b0, 1'b0, 32'h300, '0);
        total++;
        if (OutPC0 !== 32'h300 || OutValid !== 2'b01 || obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL after_reset_push: got pc0=%h v=%b want pc0=300 v=01", OutPC0, OutValid);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  $urandom, $urandom);
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random%0d: got %h want %h", k, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_stall_overpop();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
